fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Definitions shared by the core and the instruction fetch unit:
//   architectural widths, the default reset fetch address, the layout of an
//   instruction queue entry and a word-alignment helper.
//   No ports (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   // One decoded-side queue slot: instruction word plus the address it came from.
   typedef struct packed {
      logic [INST_W-1:0] data;
      logic [XLEN-1:0]   pc;
   } inst_entry_t;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Synchronous show-ahead FIFO used by the fetch unit for both the
//   instruction queue and the in-flight request tag queue.
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_flush        empty the FIFO (wins over push/pop in the same cycle)
//     i_push/i_data  write one entry
//     i_pop          consume the head entry
//     o_data         head entry (zero when empty)
//     o_full/o_empty occupancy flags
//     o_count        number of stored entries
// -----------------------------------------------------------------------------
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

   assign w_push = i_push && !o_full  && !i_flush;
   assign w_pop  = i_pop  && !o_empty && !i_flush;

   // Storage is not reset; an empty FIFO presents zero so the head is
   // well defined during and right after reset.
   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Issues word-aligned fetches under a credit
//   rule (queued + outstanding < DEPTH), matches in-order memory responses
//   to the request addresses, and queues {instruction, pc} for decode.
//   A redirect flushes everything and drops responses still in flight.
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     redirect, redirect_pc flush and restart fetch at redirect_pc
//     imem_req_valid/ready  fetch request handshake, address on imem_addr
//     imem_rsp_valid/data   in-order instruction word returns
//     inst_valid/ready      decode handshake, head on inst_data / inst_pc
//     rsp_err               sticky: a response arrived with nothing in flight
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              redirect,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_rsp_valid,
   input  logic [INST_W-1:0] imem_rsp_data,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [XLEN-1:0]   inst_pc,
   output logic              rsp_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [XLEN-1:0] r_fetch_pc;
   logic [CW-1:0]   r_outstanding;
   logic [CW-1:0]   r_discard;
   logic            r_rsp_err;

   logic [CW-1:0]   w_inst_count;
   logic [CW:0]     w_occupancy;
   logic            w_inst_empty;
   logic            w_inst_full;
   logic            w_tag_empty;
   logic            w_tag_full;
   logic [CW-1:0]   w_tag_count;
   logic [XLEN-1:0] w_tag_pc;
   logic            w_req_valid;
   logic            w_req_fire;
   logic            w_rsp_stale;
   logic            w_rsp_spurious;
   logic            w_rsp_match;
   logic            w_rsp_push;
   logic            w_inst_pop;
   inst_entry_t     w_push_entry;
   inst_entry_t     w_head;
   logic            w_unused;

   // Everything still travelling to us at a redirect becomes garbage:
   // previously discarded fetches plus live ones, less a response landing
   // in the redirect cycle itself. Saturate instead of wrapping.
   function automatic logic [CW-1:0] next_discard(input logic [CW-1:0] disc,
                                                   input logic [CW-1:0] outst,
                                                   input logic          rsp);
      logic [CW:0] sum;
      sum = {1'b0, disc} + {1'b0, outst} - {{CW{1'b0}}, rsp};
      if (sum > {1'b0, {CW{1'b1}}}) begin
         return {CW{1'b1}};
      end
      return sum[CW-1:0];
   endfunction

   // Request side: credit counts queued plus in-flight fetches.
   assign w_occupancy    = {1'b0, w_inst_count} + {1'b0, r_outstanding};
   assign w_req_valid    = !reset && !redirect && (w_occupancy < (CW+1)'(DEPTH));
   assign w_req_fire     = w_req_valid && imem_req_ready;
   assign imem_req_valid = w_req_valid;
   assign imem_addr      = align_word(r_fetch_pc);

   // Response classification: stale responses drain discard first, since
   // they were issued before any live request.
   assign w_rsp_stale    = imem_rsp_valid && (r_discard != '0);
   assign w_rsp_spurious = imem_rsp_valid && (r_discard == '0) && (r_outstanding == '0);
   assign w_rsp_match    = imem_rsp_valid && (r_discard == '0) && (r_outstanding != '0);
   assign w_rsp_push     = w_rsp_match && !redirect;

   assign w_push_entry   = '{data: imem_rsp_data, pc: w_tag_pc};

   assign inst_valid     = !w_inst_empty;
   assign w_inst_pop     = inst_valid && inst_ready;
   assign inst_data      = w_head.data;
   assign inst_pc        = w_head.pc;
   assign rsp_err        = r_rsp_err;

   // Flags that the credit rule makes redundant.
   assign w_unused = &{1'b0, w_inst_full, w_tag_empty, w_tag_full, w_tag_count};

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_flush (redirect),
      .i_push  (w_req_fire),
      .i_data  (imem_addr),
      .i_pop   (w_rsp_match),
      .o_data  (w_tag_pc),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (w_tag_count)
   );

   fetch_fifo #(
      .WIDTH ($bits(inst_entry_t)),
      .DEPTH (DEPTH)
   ) u_inst_fifo (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_flush (redirect),
      .i_push  (w_rsp_push),
      .i_data  (w_push_entry),
      .i_pop   (w_inst_pop),
      .o_data  (w_head),
      .o_full  (w_inst_full),
      .o_empty (w_inst_empty),
      .o_count (w_inst_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_rsp_err     <= 1'b0;
      end else begin
         if (redirect) begin
            r_fetch_pc    <= align_word(redirect_pc);
            r_outstanding <= '0;
            r_discard     <= next_discard(r_discard, r_outstanding,
                                          w_rsp_stale || w_rsp_match);
         end else begin
            if (w_req_fire) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_req_fire && !w_rsp_match) begin
               r_outstanding <= r_outstanding + CW'(1);
            end else if (!w_req_fire && w_rsp_match) begin
               r_outstanding <= r_outstanding - CW'(1);
            end
            if (w_rsp_stale) begin
               r_discard <= r_discard - CW'(1);
            end
         end
         if (w_rsp_spurious) begin
            r_rsp_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        rsp_err;

   fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h8000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .rsp_err        (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a memory that answers in order after 'lat' cycles,
   // an epoch number that invalidates everything requested before a
   // redirect, and the list of instructions decode should see.
   typedef struct { int due; logic [31:0] addr; int ep; } req_t;
   typedef struct { logic [31:0] data; logic [31:0] pc; } inst_t;

   req_t        memq[$];
   inst_t       instq[$];
   logic [31:0] exp_pc;
   bit          exp_err;
   int          epoch;
   int          cyc;
   int          lat;
   int          n_hs;
   int          total;
   int          bad;

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0b expected=%0b (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, check outputs against the model before
   // the edge, then advance the model with what the edge does.
   task automatic step(input logic rd, input logic [31:0] rpc, input logic ir,
                       input logic mr, input logic spur);
      logic        rv;
      logic [31:0] rdat;
      bit          from_mem;
      bit          exp_rv;
      bit          pop;
      int          live;
      int          d;
      req_t        e;
      rv = 1'b0; rdat = '0; from_mem = 0;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         rv = 1'b1; rdat = memword(memq[0].addr); from_mem = 1;
      end else if (spur && memq.size() == 0) begin
         rv = 1'b1; rdat = 32'hDEAD_BEEF;
      end
      redirect = rd; redirect_pc = rpc; inst_ready = ir; imem_req_ready = mr;
      imem_rsp_valid = rv; imem_rsp_data = rdat;
      #1;
      live = 0;
      foreach (memq[i]) if (memq[i].ep == epoch) live++;
      exp_rv = !rd && ((instq.size() + live) < DEPTH);
      chk1("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("imem_addr", imem_addr, exp_pc);
      chk1("inst_valid", inst_valid, instq.size() != 0);
      if (instq.size() != 0) begin
         chk("inst_data", inst_data, instq[0].data);
         chk("inst_pc", inst_pc, instq[0].pc);
      end
      chk1("rsp_err", rsp_err, exp_err);
      pop = (instq.size() != 0) && ir;
      @(posedge clk);
      if (pop) void'(instq.pop_front());
      if (rd) epoch++;
      if (rv) begin
         if (from_mem) begin
            e = memq.pop_front();
            if (e.ep == epoch) instq.push_back('{memword(e.addr), e.addr});
         end else begin
            exp_err = 1;
         end
      end
      if (rd) begin
         instq.delete();
         exp_pc = {rpc[31:2], 2'b00};
      end
      if (exp_rv && mr) begin
         d = cyc + lat;
         if (memq.size() > 0 && memq[memq.size()-1].due >= d) d = memq[memq.size()-1].due + 1;
         memq.push_back('{d, exp_pc, epoch});
         exp_pc = exp_pc + 32'd4;
         n_hs++;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      total = 0; bad = 0; cyc = 0; epoch = 0; n_hs = 0; exp_err = 0;
      lat = 1; exp_pc = 32'h8000_0000;
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_req_valid", imem_req_valid, 1'b0);
      chk1("rst_inst_valid", inst_valid, 1'b0);
      chk("rst_inst_data", inst_data, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk1("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_addr", imem_addr, 32'h8000_0000);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("first_req_valid", imem_req_valid, 1'b1);
      chk("first_addr", imem_addr, 32'h8000_0000);

      // Streaming at latency 1: one instruction per cycle from cycle 2.
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      chk1("stream_c2_valid", inst_valid, 1'b1);
      chk("stream_c2_pc", inst_pc, 32'h8000_0000);
      repeat (4) step(0, 0, 1, 1, 0);
      chk("stream_c6_pc", inst_pc, 32'h8000_0010);

      // Decode stalled for 10 cycles from an empty state: exactly DEPTH requests.
      step(1, 32'h8000_0200, 0, 1, 0);
      n0 = n_hs;
      repeat (10) step(0, 0, 0, 1, 0);
      chk("stall_req_count", n_hs - n0, DEPTH);
      redirect = 1'b0; #1;
      chk1("stall_req_low", imem_req_valid, 1'b0);
      chk("stall_head_pc", inst_pc, 32'h8000_0200);
      repeat (8) step(0, 0, 1, 1, 0);

      // Latency 3, redirect to an unaligned target with fetches in flight.
      lat = 3;
      repeat (8) step(0, 0, 1, 1, 0);
      step(1, 32'h8000_0103, 1, 1, 0);
      redirect = 1'b0; #1;
      chk1("redir_inst_valid", inst_valid, 1'b0);
      chk1("redir_req_valid", imem_req_valid, 1'b1);
      chk("redir_addr", imem_addr, 32'h8000_0100);
      for (int i = 0; i < 20 && !inst_valid; i++) step(0, 0, 0, 1, 0);
      chk1("redir_got_inst", inst_valid, 1'b1);
      chk("redir_first_pc", inst_pc, 32'h8000_0100);
      repeat (6) step(0, 0, 1, 1, 0);

      // Redirect together with a response and a pop, latency 2.
      lat = 2;
      repeat (6) step(0, 0, 1, 1, 0);
      step(1, 32'h8000_0400, 1, 1, 0);
      chk1("redir_pop_err", rsp_err, 1'b0);
      repeat (8) step(0, 0, 1, 1, 0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 31) == 0) lat = $urandom_range(1, 3);
         step($urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, 0);
      end

      // Address wrap at the top of the address space.
      lat = 1;
      step(1, 32'hFFFF_FFF8, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      step(0, 0, 1, 1, 0);
      chk("wrap_addr", imem_addr, 32'h0000_0000);
      repeat (3) step(0, 0, 1, 1, 0);

      // Spurious response while idle: sticky error, queue untouched.
      repeat (8) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk1("spurious_err", rsp_err, 1'b1);
      repeat (6) step(0, 0, 1, 0, 0);
      chk1("spurious_err_sticky", rsp_err, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
